// File: rtl/cpu_defs.sv
// Shared definitions for the pipeline hazard controller.
//   - Forward-select encodings driven onto the EX operand muxes.
//   - FSM state encoding for the data-memory freeze sequencer.
package cpu_defs;

    // EX operand source selects
    localparam logic [1:0] FWD_RF      = 2'b00;  // register file value from ID/EX
    localparam logic [1:0] FWD_EXALU   = 2'b01;  // ALU result of the EX-stage instruction
    localparam logic [1:0] FWD_MEMALU  = 2'b10;  // ALU result held in the MEM stage
    localparam logic [1:0] FWD_MEMDATA = 2'b11;  // load data returned in the MEM stage

    // Memory sequencer states
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] MWAIT = 1'b1;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forward select for the EX stage.
// Ports:
//   src    in  5  ID source register being resolved
//   ern    in  5  EX destination register
//   ewreg  in  1  EX writes the register file
//   em2reg in  1  EX instruction is a load
//   mrn    in  5  MEM destination register
//   mwreg  in  1  MEM writes the register file
//   mm2reg in  1  MEM instruction is a load
//   sel    out 2  operand source select (cpu_defs FWD_* encoding)
module fwd_sel
    import cpu_defs::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] mrn,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] sel
);

    // The EX producer is the youngest, so it wins over MEM. An EX load has no
    // data yet; that case is covered by the load-use stall instead.
    always_comb begin
        sel = FWD_RF;
        if (ewreg && !em2reg && (ern != 5'd0) && (ern == src)) begin
            sel = FWD_EXALU;
        end else if (mwreg && !mm2reg && (mrn != 5'd0) && (mrn == src)) begin
            sel = FWD_MEMALU;
        end else if (mwreg && mm2reg && (mrn != 5'd0) && (mrn == src)) begin
            sel = FWD_MEMDATA;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// Freezes the whole pipe while a data-memory access is outstanding (with a
// watchdog), inserts a bubble on load-use hazards, flushes IF/ID on taken
// branches when there is no delay slot, and selects EX operand forwarding.
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   rs, rt, use_rs, use_rt    ID source registers and their use flags
//   br_taken                  ID branch/jump resolved taken
//   ern, ewreg, em2reg        EX destination, write enable, load flag
//   mrn, mwreg, mm2reg, mwmem MEM destination, write enable, load, store
//   dmem_rdy                  data memory completes the MEM access
//   pc_wen, ifid_wen, pipe_wen  register enables (0 = hold)
//   id_bubble, ifid_flush     ID control zeroing and IF/ID clear
//   fwda, fwdb                EX operand forward selects
//   mem_timeout               sticky watchdog-expiry flag
//   stall_cnt                 saturating count of cycles with pc_wen=0
module pipe_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 16,
    parameter int DELAY_SLOT = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             br_taken,
    input  logic [4:0]       ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mwmem,
    input  logic             dmem_rdy,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             pipe_wen,
    output logic             id_bubble,
    output logic             ifid_flush,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int            WW        = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);
    localparam logic          FLUSH_EN  = (DELAY_SLOT == 0);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          freeze;
    logic          timeout_evt;
    logic          lstall;
    logic          mem_req;
    logic [1:0]    fwda_raw;
    logic [1:0]    fwdb_raw;

    assign mem_req = mm2reg | mwmem;

    assign lstall = ewreg & em2reg & (ern != 5'd0) &
                    ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

    // Memory sequencer. wait_cnt counts frozen cycles of the current access;
    // the cycle that finds it at MAX_WAIT-1 releases the pipe anyway so a
    // dead memory cannot hang the core. mem_req is not looked at in MWAIT
    // because the MEM stage is held and still presents the same access.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        freeze      = 1'b0;
        timeout_evt = 1'b0;
        if (state == RUN) begin
            if (mem_req && !dmem_rdy) begin
                freeze    = 1'b1;
                state_nxt = MWAIT;
                wait_nxt  = WW'(1);
            end
        end else begin
            if (dmem_rdy) begin
                state_nxt = RUN;
            end else if (wait_cnt == LAST_WAIT) begin
                state_nxt   = RUN;
                timeout_evt = 1'b1;
            end else begin
                freeze   = 1'b1;
                wait_nxt = wait_cnt + 1'b1;
            end
        end
    end

    // Enables with priority freeze > load-use > branch; all forced low in reset.
    always_comb begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        pipe_wen   = 1'b0;
        id_bubble  = 1'b0;
        ifid_flush = 1'b0;
        if (clrn && !freeze) begin
            if (lstall) begin
                pipe_wen  = 1'b1;
                id_bubble = 1'b1;
            end else begin
                pc_wen     = 1'b1;
                ifid_wen   = 1'b1;
                pipe_wen   = 1'b1;
                ifid_flush = br_taken & FLUSH_EN;
            end
        end
    end

    // State, watchdog flag and the saturating stall counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_evt) begin
                mem_timeout <= 1'b1;
            end
            if ((freeze || lstall) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    fwd_sel u_fwd_a (
        .src    (rs),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrn    (mrn),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .sel    (fwda_raw)
    );

    fwd_sel u_fwd_b (
        .src    (rt),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrn    (mrn),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .sel    (fwdb_raw)
    );

    assign fwda = clrn ? fwda_raw : FWD_RF;
    assign fwdb = clrn ? fwdb_raw : FWD_RF;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the PC write enable (LOADDEPEN of the PC register), the IF/ID and downstream pipeline-register enables, the ID-stage bubble and flush, and the EX operand forward selects.
- Detects load-use hazards and freezes the pipe while a data-memory access is outstanding, with a watchdog timeout.
- Counts stall cycles for performance monitoring.

Parameters:
- MAX_WAIT, 16: maximum freeze cycles per data-memory access before timeout (>=2).
- CNT_W, 16: width of the saturating stall counter.
- DELAY_SLOT, 1: 1 = branch delay slot, so ifid_flush is never asserted; 0 = flush IF/ID on a taken branch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- rs  in  5  ID source register A.
- rt  in  5  ID source register B.
- use_rs  in  1  ID instruction reads rs.
- use_rt  in  1  ID instruction reads rt.
- br_taken  in  1  ID branch/jump resolved taken.
- ern  in  5  EX destination register.
- ewreg  in  1  EX writes the register file.
- em2reg  in  1  EX instruction is a load.
- mrn  in  5  MEM destination register.
- mwreg  in  1  MEM writes the register file.
- mm2reg  in  1  MEM instruction is a load.
- mwmem  in  1  MEM instruction is a store.
- dmem_rdy  in  1  data memory completes the MEM-stage access this cycle.
- pc_wen  out  1  PC load enable; 0 = hold.
- ifid_wen  out  1  IF/ID register enable.
- pipe_wen  out  1  ID/EX, EX/MEM and MEM/WB register enable.
- id_bubble  out  1  zero the ID-stage write controls (wreg, m2reg, wmem) into ID/EX.
- ifid_flush  out  1  clear IF/ID to a NOP.
- fwda  out  2  operand A select.
- fwdb  out  2  operand B select.
- mem_timeout  out  1  sticky; a watchdog expiry has occurred.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_wen=0.

Behaviour:
- Reset (clrn=0, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0. While clrn=0, all enables, id_bubble and ifid_flush are forced to 0, and fwda/fwdb are forced to 00.
- mem_req = mm2reg | mwmem.
- FSM states are RUN and MWAIT.
  - RUN, with mem_req & !dmem_rdy: freeze=1 this cycle; next state MWAIT; wait_cnt<=1.
  - MWAIT, with dmem_rdy=1: freeze=0 (release this cycle); next state RUN.
  - MWAIT, with dmem_rdy=0 and wait_cnt==MAX_WAIT-1: freeze=0 (forced release); mem_timeout<=1; next state RUN.
  - MWAIT, otherwise: freeze=1; wait_cnt increments.
  - mem_req is ignored in MWAIT, because MEM is frozen.
- Load-use stall: lstall = ewreg & em2reg & (ern!=0) & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- Output priority is freeze > lstall > branch.
  - freeze: pc_wen=0, ifid_wen=0, pipe_wen=0, id_bubble=0, ifid_flush=0.
  - lstall (not frozen): pc_wen=0, ifid_wen=0, pipe_wen=1, id_bubble=1, ifid_flush=0.
  - br_taken & DELAY_SLOT==0, neither of the above: ifid_flush=1. Enables stay 1.
  - default: pc_wen=ifid_wen=pipe_wen=1, bubble=flush=0.
- Forwarding for fwda (rs); fwdb is identical with rt:
  - 01 if ewreg & !em2reg & ern!=0 & ern==rs;
  - else 10 if mwreg & !mm2reg & mrn!=0 & mrn==rs;
  - else 11 if mwreg & mm2reg & mrn!=0 & mrn==rs;
  - else 00.
  - EX has priority over MEM.
  - Forward selects stay valid during a stall.
- stall_cnt increments every clk with clrn=1 and pc_wen=0. It saturates at all-ones and never wraps.
- mem_timeout is cleared only by reset.
- Reset asserted mid-MWAIT returns to RUN immediately. No partial count survives.

Decomposition:
- Shared package (cpu_defs): fwd select constants FWD_RF=00, FWD_EXALU=01, FWD_MEMALU=10, FWD_MEMDATA=11; FSM state encoding RUN/MWAIT.
- One sub-module, fwd_sel: combinational single-operand forward mux select, instanced twice (rs, rt).
- The FSM, stall logic and counters stay in the top module.

Test Plan:
- Load-use: EX lw $3 (ewreg=1, em2reg=1, ern=3), ID rs=3, use_rs=1 -> pc_wen=0, ifid_wen=0, id_bubble=1 for one cycle, stall_cnt 0->1. Next cycle, with EX holding the bubble and MEM holding the load, fwda=11.
- Forwarding: ern=5 ALU, mrn=5 ALU, rs=rt=5 -> fwda=fwdb=01. With ern=0 and rs=0 -> fwda=00.
- Memory wait: mm2reg=1, dmem_rdy low for 3 cycles then high -> freeze for 3 cycles (all enables 0), released on the rdy cycle, stall_cnt +=3, state back to RUN.
- Timeout: MAX_WAIT=4, mwmem=1, dmem_rdy held 0 -> 3 frozen cycles, forced release in cycle 4, mem_timeout=1 and stays 1.
- Priority: freeze with lstall and br_taken (DELAY_SLOT=0) all true -> only the freeze outputs appear, no flush. After release, lstall is applied without flush. Then br_taken alone -> ifid_flush=1.
- Reset: clrn pulsed low during MWAIT and asynchronously to clk -> outputs zeroed immediately, stall_cnt=0, mem_timeout=0. After release the block is in RUN.
